shiftadd_reduce_multi: RTL and testbench

SHIFTADD_REDUCE_MULTI -- requirements
Module: shiftadd_reduce_multi

---
 rtl/multiplier_pkg.sv | 20 ++
 rtl/shiftadd_reduce_multi_if.sv | 30 +++
 rtl/mersenne_fold.sv | 18 +
 rtl/shiftadd_reduce_multi.sv | 155 +++++++++++++++
 tb/tb_shiftadd_reduce_multi.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the modular-reduction datapath: default data width,
// reduction modes and the reducer FSM state encoding.
package multiplier_pkg;

  localparam int DATA_LENGTH = 32;

  typedef enum logic [1:0] {
    GENERIC  = 2'd0,
    MERSENNE = 2'd1
  } reduce_mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_GEN = 3'd1,
    RUN_MER = 3'd2,
    CORR    = 3'd3,
    DONE    = 3'd4
  } reduce_state_e;

endpackage

// File: rtl/shiftadd_reduce_multi_if.sv
// Request/response bundle of the reducer; master drives the request side.
interface shiftadd_reduce_multi_if
  import multiplier_pkg::*;
#(
  parameter int W  = DATA_LENGTH,
  parameter int XW = 2 * W
);
  localparam int KW = $clog2(W) + 1;

  logic          start_i;
  logic [1:0]    mode_i;
  logic [XW-1:0] x_i;
  logic [W-1:0]  m_i;
  logic [KW-1:0] m_bl_i;
  logic [W-1:0]  result_o;
  logic          valid_o;
  logic          busy_o;
  logic          error_o;

  modport master (
    output start_i, mode_i, x_i, m_i, m_bl_i,
    input  result_o, valid_o, busy_o, error_o
  );

  modport slave (
    input  start_i, mode_i, x_i, m_i, m_bl_i,
    output result_o, valid_o, busy_o, error_o
  );

endinterface

// File: rtl/mersenne_fold.sv
// One fold step for a Mersenne modulus 2^k-1: v' = (v & mask) + (v >> k),
// with done_o flagging that v' already fits in k bits.
module mersenne_fold #(
  parameter int XW = 64,
  parameter int KW = 6
) (
  input  logic [XW:0]   v_i,
  input  logic [KW-1:0] k_i,
  output logic [XW:0]   v_o,
  output logic [XW:0]   mask_o,
  output logic          done_o
);

  assign mask_o = ((XW+1)'(1) << k_i) - (XW+1)'(1);
  assign v_o    = (v_i & mask_o) + (v_i >> k_i);
  assign done_o = (v_o <= mask_o);

endmodule

// File: rtl/shiftadd_reduce_multi.sv
// Multi-cycle x mod m: bit-serial shift-subtract for generic moduli, or
// repeated folding for Mersenne moduli 2^k-1 followed by a final correction.
module shiftadd_reduce_multi
  import multiplier_pkg::*;
#(
  parameter int W  = DATA_LENGTH,
  parameter int XW = 2 * W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [XW-1:0]        x_i,
  input  logic [W-1:0]         m_i,
  input  logic [$clog2(W):0]   m_bl_i,
  output logic [W-1:0]         result_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 error_o
);

  localparam int KW = $clog2(W) + 1;
  localparam int IW = $clog2(XW);
  localparam int CW = $clog2(XW + 2);
  localparam int DW = CW + 1;

  reduce_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [W-1:0]  m_q, m_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  r_q, r_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [XW:0]   v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lim_q, lim_d;
  logic [W-1:0]  result_q, result_d;
  logic          error_q, error_d;

  logic [W:0]    r_sh, r_nx;
  logic [XW:0]   start_mask;
  logic          mer_ok;
  logic [DW-1:0] k_div, lim_quot;
  logic [XW:0]   fold_v, fold_mask;
  logic          fold_done;

  mersenne_fold #(.XW(XW), .KW(KW)) u_fold (
    .v_i    (v_q),
    .k_i    (k_q),
    .v_o    (fold_v),
    .mask_o (fold_mask),
    .done_o (fold_done)
  );

  // r < m holds between steps, so the shifted value needs only one extra bit
  assign r_sh = {r_q, x_q[idx_q]};
  assign r_nx = (r_sh >= {1'b0, m_q}) ? (r_sh - {1'b0, m_q}) : r_sh;

  assign start_mask = ((XW+1)'(1) << m_bl_i) - (XW+1)'(1);
  assign mer_ok     = (m_i != '0) && ({{(XW+1-W){1'b0}}, m_i} == start_mask);
  assign k_div      = (m_bl_i == '0) ? DW'(1) : DW'(m_bl_i);
  // Fold budget ceil(XW/k)+1; a valid Mersenne operand always settles within it
  assign lim_quot   = (DW'(XW) + k_div - DW'(1)) / k_div;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    m_d      = m_q;
    k_d      = k_q;
    r_d      = r_q;
    idx_d    = idx_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    lim_d    = lim_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d   = x_i;
          m_d   = m_i;
          k_d   = m_bl_i;
          r_d   = '0;
          idx_d = IW'(XW - 1);
          v_d   = {1'b0, x_i};
          cnt_d = '0;
          lim_d = CW'(lim_quot + DW'(1));
          if (reduce_mode_e'(mode_i) == MERSENNE) begin
            state_d = mer_ok ? RUN_MER : DONE;
          end else begin
            state_d = (m_i != '0) ? RUN_GEN : DONE;
          end
          if (state_d == DONE) begin
            result_d = '0;
            error_d  = 1'b1;
          end
        end
      end
      RUN_GEN: begin
        r_d   = r_nx[W-1:0];
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          result_d = r_nx[W-1:0];
          error_d  = 1'b0;
          state_d  = DONE;
        end
      end
      RUN_MER: begin
        v_d   = fold_v;
        cnt_d = cnt_q + CW'(1);
        if (fold_done || (cnt_q + CW'(1) >= lim_q)) state_d = CORR;
      end
      CORR: begin
        result_d = (v_q == fold_mask) ? '0 : v_q[W-1:0];
        error_d  = 1'b0;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      x_q      <= '0;
      m_q      <= '0;
      k_q      <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      lim_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      m_q      <= m_d;
      k_q      <= k_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign result_o = result_q;
  assign error_o  = error_q;
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_shiftadd_reduce_multi.sv
// Directed and randomized checks of shiftadd_reduce_multi at W=32, XW=64.
module tb_shiftadd_reduce_multi;

  localparam int LIMIT = 200;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  shiftadd_reduce_multi_if #(.W(32), .XW(64)) bus ();

  shiftadd_reduce_multi #(.W(32), .XW(64)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (bus.start_i),
    .mode_i   (bus.mode_i),
    .x_i      (bus.x_i),
    .m_i      (bus.m_i),
    .m_bl_i   (bus.m_bl_i),
    .result_o (bus.result_o),
    .valid_o  (bus.valid_o),
    .busy_o   (bus.busy_o),
    .error_o  (bus.error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns in the idle cycle after DONE.
  task automatic run_op(input logic [1:0] md, input logic [63:0] x, input logic [31:0] m,
                        input logic [5:0] k, input int repulse,
                        output int cyc, output logic [31:0] res, output logic err);
    logic seen;
    bus.start_i = 1'b1;
    bus.mode_i  = md;
    bus.x_i     = x;
    bus.m_i     = m;
    bus.m_bl_i  = k;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.x_i     = ~x;
    bus.m_i     = m ^ 32'h5A5A_A5A5;
    bus.m_bl_i  = k ^ 6'h15;
    bus.mode_i  = ~md;
    cyc = 1;
    check("busy_after_start", {63'd0, bus.busy_o}, 64'd1);
    while (!bus.valid_o && cyc < LIMIT) begin
      if (cyc == repulse) begin
        bus.start_i = 1'b1;
        bus.x_i     = 64'd5;
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start_i = 1'b0;
    seen = bus.valid_o;
    check("valid_seen", {63'd0, seen}, 64'd1);
    res = bus.result_o;
    err = bus.error_o;
    @(posedge clk);
    #1;
    check("valid_one_cycle", {63'd0, bus.valid_o}, 64'd0);
    check("idle_after_done", {63'd0, bus.busy_o}, 64'd0);
    check("result_hold", {32'd0, bus.result_o}, {32'd0, res});
    check("error_hold", {63'd0, bus.error_o}, {63'd0, err});
  endtask

  initial begin
    int          cyc;
    logic [31:0] res;
    logic        err;
    logic [63:0] x;
    logic [31:0] m;
    logic [5:0]  k;
    logic        seen;
    int          bound;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.mode_i  = 2'd0;
    bus.x_i     = '0;
    bus.m_i     = '0;
    bus.m_bl_i  = '0;
    @(posedge clk);
    #1;
    check("rst_result", {32'd0, bus.result_o}, 64'd0);
    check("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_error", {63'd0, bus.error_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // generic reference vector: 2^32 mod (2^31+1) = 2^31-1
    run_op(2'd0, 64'h0000_0001_0000_0000, 32'h8000_0001, 6'd0, 0, cyc, res, err);
    check("gen_ref_res", {32'd0, res}, 64'h7FFF_FFFF);
    check("gen_ref_err", {63'd0, err}, 64'd0);
    check("gen_ref_cyc", 64'(cyc), 64'd65);

    // error cases complete one cycle after the start edge
    run_op(2'd0, 64'd123, 32'd0, 6'd0, 0, cyc, res, err);
    check("gen_m0_err", {63'd0, err}, 64'd1);
    check("gen_m0_res", {32'd0, res}, 64'd0);
    check("gen_m0_cyc", 64'(cyc), 64'd1);
    run_op(2'd1, 64'd123, 32'd0, 6'd5, 0, cyc, res, err);
    check("mer_m0_err", {63'd0, err}, 64'd1);
    check("mer_m0_cyc", 64'(cyc), 64'd1);
    run_op(2'd1, 64'd77, 32'h8000_0001, 6'd32, 0, cyc, res, err);
    check("mer_bad_err", {63'd0, err}, 64'd1);
    check("mer_bad_res", {32'd0, res}, 64'd0);
    check("mer_bad_cyc", 64'(cyc), 64'd1);

    // Mersenne 2^31-1: (2^64-1) mod m = 3, and x = m reduces to 0 in the correction step
    run_op(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h7FFF_FFFF, 6'd31, 0, cyc, res, err);
    check("mer_ones_res", {32'd0, res}, 64'd3);
    check("mer_ones_err", {63'd0, err}, 64'd0);
    run_op(2'd1, 64'h7FFF_FFFF, 32'h7FFF_FFFF, 6'd31, 0, cyc, res, err);
    check("mer_corr_res", {32'd0, res}, 64'd0);
    run_op(2'd1, 64'd100, 32'd7, 6'd3, 0, cyc, res, err);
    check("mer_k3_res", {32'd0, res}, 64'd2);
    run_op(2'd1, 64'hFF, 32'd1, 6'd1, 0, cyc, res, err);
    check("mer_k1_res", {32'd0, res}, 64'd0);
    check("mer_k1_err", {63'd0, err}, 64'd0);

    // mode 3 behaves as generic: 50 mod 8 = 2 in the full 65-cycle schedule
    run_op(2'd3, 64'd50, 32'd8, 6'd0, 0, cyc, res, err);
    check("mode3_res", {32'd0, res}, 64'd2);
    check("mode3_cyc", 64'(cyc), 64'd65);

    // start re-pulsed mid RUN_GEN is ignored: 1000 mod 7 = 6
    run_op(2'd0, 64'd1000, 32'd7, 6'd0, 10, cyc, res, err);
    check("repulse_res", {32'd0, res}, 64'd6);
    check("repulse_cyc", 64'(cyc), 64'd65);
    // back-to-back start in the cycle after DONE: 100 mod 9 = 1
    run_op(2'd0, 64'd100, 32'd9, 6'd0, 0, cyc, res, err);
    check("b2b_res", {32'd0, res}, 64'd1);
    check("b2b_cyc", 64'(cyc), 64'd65);

    // reset in the middle of RUN_GEN
    bus.start_i = 1'b1;
    bus.mode_i  = 2'd0;
    bus.x_i     = 64'd1000;
    bus.m_i     = 32'd7;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, bus.busy_o}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_result", {32'd0, bus.result_o}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("mid_rst_valid", {63'd0, bus.valid_o}, 64'd0);
    check("mid_rst_error", {63'd0, bus.error_o}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) seen = 1'b1;
    end
    check("no_valid_after_rst", {63'd0, seen}, 64'd0);
    run_op(2'd0, 64'd1000, 32'd13, 6'd0, 0, cyc, res, err);
    check("post_rst_res", {32'd0, res}, 64'd12);
    check("post_rst_cyc", 64'(cyc), 64'd65);

    // random generic operands against x % m
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      m = $urandom >> $urandom_range(0, 31);
      if (m == 32'd0) m = 32'd1;
      run_op(2'd0, x, m, 6'($urandom_range(0, 63)), 0, cyc, res, err);
      check("rnd_gen_res", {32'd0, res}, x % {32'd0, m});
      check("rnd_gen_err", {63'd0, err}, 64'd0);
      check("rnd_gen_cyc", 64'(cyc), 64'd65);
    end

    // random Mersenne operands against x % (2^k-1), within the fold budget
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      k = 6'($urandom_range(1, 32));
      m = 32'((64'd1 << k) - 64'd1);
      run_op(2'd1, x, m, k, 0, cyc, res, err);
      bound = (64 + int'(k) - 1) / int'(k) + 3;
      check("rnd_mer_res", {32'd0, res}, x % {32'd0, m});
      check("rnd_mer_err", {63'd0, err}, 64'd0);
      check("rnd_mer_bound", {63'd0, cyc <= bound}, 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
